// File: rtl/ht_dec_pkg.sv
// Shared sizes and FSM state type for the serial Huffman decoder.
package ht_dec_pkg;

    localparam int NUM_SYM = 8;
    localparam int SYM_W   = 3;
    localparam int MAX_LEN = 7;
    localparam int LEN_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/ht_dec_match.sv
// Combinational table lookup: finds the lowest-index entry whose length equals
// the bit count and whose low code bits equal the accumulated bits.
module ht_dec_match
    import ht_dec_pkg::*;
(
    input  logic [LEN_W-1:0]   i_tbl_len  [NUM_SYM],
    input  logic [MAX_LEN-1:0] i_tbl_code [NUM_SYM],
    input  logic [MAX_LEN-1:0] i_nacc,
    input  logic [LEN_W-1:0]   i_ncnt,
    output logic               o_hit,
    output logic [SYM_W-1:0]   o_sym
);

    logic [MAX_LEN:0]   w_mask_full;
    logic [MAX_LEN-1:0] w_mask;

    assign w_mask_full = ((MAX_LEN+1)'(1) << i_ncnt) - (MAX_LEN+1)'(1);
    assign w_mask      = w_mask_full[MAX_LEN-1:0];

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        o_hit = 1'b0;
        o_sym = '0;
        for (int k = NUM_SYM - 1; k >= 0; k--) begin
            if ((i_tbl_len[k] == i_ncnt) &&
                (((i_tbl_code[k] ^ i_nacc) & w_mask) == '0)) begin
                o_hit = 1'b1;
                o_sym = SYM_W'(k);
            end
        end
    end

endmodule

// File: rtl/ht_dec.sv
// Serial Huffman decoder: loads an 8-entry code table, then shifts in one code
// bit per valid cycle and emits the symbol index when a table entry matches.
module ht_dec
    import ht_dec_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tbl_valid,
    input  logic [LEN_W-1:0]   tbl_len,
    input  logic [MAX_LEN-1:0] tbl_code,
    input  logic               in_valid,
    input  logic               in_code,
    output logic               tbl_ready,
    output logic               out_valid,
    output logic [SYM_W-1:0]   out_sym,
    output logic               err
);

    state_t             r_state, w_state_nxt;
    logic [SYM_W-1:0]   r_ld_cnt, w_ld_cnt_nxt;
    logic               w_tbl_we;
    logic [SYM_W-1:0]   w_tbl_idx;

    logic [LEN_W-1:0]   r_tbl_len  [NUM_SYM];
    logic [MAX_LEN-1:0] r_tbl_code [NUM_SYM];

    logic [MAX_LEN-1:0] r_acc;
    logic [LEN_W-1:0]   r_cnt;
    logic [MAX_LEN-1:0] w_nacc;
    logic [LEN_W-1:0]   w_ncnt;
    logic               w_hit;
    logic [SYM_W-1:0]   w_sym;
    logic               w_dec_en;
    logic               w_restart;
    logic               w_full;

    logic               r_out_valid;
    logic [SYM_W-1:0]   r_out_sym;
    logic               r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ld_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ld_cnt <= w_ld_cnt_nxt;
        end
    end

    // A table strobe in IDLE or RUN always (re)starts with entry 0.
    always_comb begin
        w_state_nxt  = r_state;
        w_ld_cnt_nxt = r_ld_cnt;
        w_tbl_we     = 1'b0;
        w_tbl_idx    = '0;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (tbl_valid) begin
                    w_tbl_we     = 1'b1;
                    w_tbl_idx    = '0;
                    w_ld_cnt_nxt = SYM_W'(1);
                    w_state_nxt  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (tbl_valid) begin
                    w_tbl_we     = 1'b1;
                    w_tbl_idx    = r_ld_cnt;
                    w_ld_cnt_nxt = r_ld_cnt + SYM_W'(1);
                    if (r_ld_cnt == SYM_W'(NUM_SYM - 1)) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_ld_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_SYM; k++) begin
                r_tbl_len[k]  <= '0;
                r_tbl_code[k] <= '0;
            end
        end else if (w_tbl_we) begin
            r_tbl_len[w_tbl_idx]  <= tbl_len;
            r_tbl_code[w_tbl_idx] <= tbl_code;
        end
    end

    assign w_restart = (r_state == ST_RUN) && tbl_valid;
    assign w_dec_en  = (r_state == ST_RUN) && in_valid && !tbl_valid;
    assign w_nacc    = {r_acc[MAX_LEN-2:0], in_code};
    assign w_ncnt    = r_cnt + LEN_W'(1);
    assign w_full    = (w_ncnt == LEN_W'(MAX_LEN));

    ht_dec_match u_match (
        .i_tbl_len  (r_tbl_len),
        .i_tbl_code (r_tbl_code),
        .i_nacc     (w_nacc),
        .i_ncnt     (w_ncnt),
        .o_hit      (w_hit),
        .o_sym      (w_sym)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sym   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= w_dec_en && w_hit;
            r_out_sym   <= (w_dec_en && w_hit) ? w_sym : '0;
            r_err       <= w_dec_en && !w_hit && w_full;
            if (w_restart) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_dec_en) begin
                if (w_hit || w_full) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_nacc;
                    r_cnt <= w_ncnt;
                end
            end
        end
    end

    assign tbl_ready = (r_state == ST_RUN);
    assign out_valid = r_out_valid;
    assign out_sym   = r_out_sym;
    assign err       = r_err;

endmodule

// File: tb/tb_ht_dec.sv
// Self-checking bench for ht_dec: directed table/bitstream scenarios plus
// randomized traffic, compared cycle by cycle with a table-lookup reference model.
module tb_ht_dec;

    logic       clk;
    logic       rst_n;
    logic       tbl_valid;
    logic [2:0] tbl_len;
    logic [6:0] tbl_code;
    logic       in_valid;
    logic       in_code;
    logic       tbl_ready;
    logic       out_valid;
    logic [2:0] out_sym;
    logic       err;

    ht_dec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tbl_valid (tbl_valid),
        .tbl_len   (tbl_len),
        .tbl_code  (tbl_code),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .tbl_ready (tbl_ready),
        .out_valid (out_valid),
        .out_sym   (out_sym),
        .err       (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         n_vec;
    int         n_err;
    int         m_loaded;
    int         m_val;
    int         m_n;
    int         m_len  [8];
    int         m_code [8];
    logic [2:0] exp_q[$];
    logic       exp_ready;
    logic       exp_ov;
    logic [2:0] exp_sym;
    logic       exp_err;

    int         t_len  [8];
    int         t_code [8];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_loaded = 0;
        m_val    = 0;
        m_n      = 0;
        for (int k = 0; k < 8; k++) begin
            m_len[k]  = 0;
            m_code[k] = 0;
        end
        exp_q.delete();
    endtask

    // One clock of behaviour: a table strobe loads the next entry (restarting
    // after a complete table); otherwise a bit extends the received prefix.
    task automatic model_step(input logic tv, input int tl, input int tc,
                              input logic iv, input logic ic);
        bit found;
        exp_ov  = 1'b0;
        exp_sym = 3'd0;
        exp_err = 1'b0;
        if (tv) begin
            if (m_loaded == 8) begin
                m_loaded = 0;
                m_val    = 0;
                m_n      = 0;
            end
            m_len[m_loaded]  = tl;
            m_code[m_loaded] = tc;
            m_loaded++;
        end else if (iv && m_loaded == 8) begin
            m_val = m_val * 2 + int'(ic);
            m_n++;
            found = 0;
            for (int k = 0; k < 8; k++) begin
                if (!found && m_len[k] == m_n && (m_code[k] % (1 << m_n)) == m_val) begin
                    found   = 1;
                    exp_ov  = 1'b1;
                    exp_sym = 3'(k);
                end
            end
            if (found) begin
                exp_q.push_back(exp_sym);
                m_val = 0;
                m_n   = 0;
            end else if (m_n == 7) begin
                exp_err = 1'b1;
                m_val   = 0;
                m_n     = 0;
            end
        end
        exp_ready = (m_loaded == 8);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic tv, input int tl, input int tc,
                         input logic iv, input logic ic);
        tbl_valid = tv;
        tbl_len   = 3'(tl);
        tbl_code  = 7'(tc);
        in_valid  = iv;
        in_code   = ic;
        model_step(tv, tl, tc, iv, ic);
        @(negedge clk);
        check_eq("tbl_ready", 32'(tbl_ready), 32'(exp_ready));
        check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
        check_eq("out_sym",   32'(out_sym),   32'(exp_sym));
        check_eq("err",       32'(err),       32'(exp_err));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_sym", 32'(out_sym), 32'hffff_ffff);
            end else begin
                check_eq("sb_sym", 32'(out_sym), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        tbl_valid = 1'b0;
        tbl_len   = '0;
        tbl_code  = '0;
        in_valid  = 1'b0;
        in_code   = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        check_eq("rst_tbl_ready", 32'(tbl_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_sym",   32'(out_sym),   32'd0);
        check_eq("rst_err",       32'(err),       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_table_t(input bit dup7);
        for (int k = 0; k < 7; k++) begin
            t_len[k]  = k + 1;
            t_code[k] = (1 << (k + 1)) - 2;
        end
        t_len[7]  = 7;
        t_code[7] = dup7 ? 126 : 127;
    endtask

    task automatic load_from(input int start, input bit gaps);
        for (int k = start; k < 8; k++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int i = 0; i < g; i++) cycle(1'b0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            cycle(1'b1, t_len[k], t_code[k], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cycle(1'b0, 0, 0, 1'b1, bits[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        reset_dut();

        // Table T load, then "10" -> sym1
        set_table_t(1'b0);
        load_from(0, 1'b1);
        send_bits(32'b10, 2);
        idle_cycles(2);

        // Back-to-back stream -> sym0, sym7, sym2
        send_bits(32'b0_1111111_110, 11);
        idle_cycles(2);

        // Duplicate table: 1111110 -> sym6, 1111111 -> err, 0 -> sym0
        set_table_t(1'b1);
        load_from(0, 1'b0);
        send_bits(32'b1111110, 7);
        send_bits(32'b1111111, 7);
        send_bits(32'b0, 1);
        idle_cycles(1);

        // Mid-code gap: 1, five idle cycles, 1,0 -> sym2
        set_table_t(1'b0);
        load_from(0, 1'b0);
        send_bits(32'b1, 1);
        idle_cycles(5);
        send_bits(32'b10, 2);
        idle_cycles(1);

        // Bits ignored outside RUN; restart in RUN after "11" drops the bit
        reset_dut();
        send_bits(32'b0101, 4);
        cycle(1'b1, t_len[0], t_code[0], 1'b1, 1'b0);
        send_bits(32'b00, 2);
        load_from(1, 1'b1);
        send_bits(32'b11, 2);
        cycle(1'b1, t_len[0], t_code[0], 1'b1, 1'b0);
        load_from(1, 1'b0);
        send_bits(32'b0, 1);
        idle_cycles(1);

        // Async reset mid-code, then bits ignored until reload
        send_bits(32'b111, 3);
        reset_dut();
        send_bits(32'b0010, 4);
        load_from(0, 1'b0);
        send_bits(32'b110, 3);

        // Randomized tables and traffic
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 4) == 0) reset_dut();
            if (r % 2 == 0) begin
                set_table_t(1'($urandom_range(0, 1)));
            end else begin
                for (int k = 0; k < 8; k++) begin
                    t_len[k]  = $urandom_range(0, 7);
                    t_code[k] = $urandom_range(0, 127);
                end
            end
            load_from(0, 1'b1);
            for (int i = 0; i < 120; i++) begin
                logic tv;
                tv = ($urandom_range(0, 99) < 3);
                cycle(tv, $urandom_range(0, 7), $urandom_range(0, 127),
                      ($urandom_range(0, 99) < 75), 1'($urandom_range(0, 1)));
            end
        end

        idle_cycles(2);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
